// File: rtl/lookup_table_reli_tx_pkg.sv
// Shared definitions for the reliable-TX lookup path: key layout and field offsets.
package lookup_table_reli_tx_pkg;

  localparam int unsigned RSIP_INDEX_WIDTH = 5;
  localparam int unsigned DST_IP_WIDTH     = 128;
  localparam int unsigned KEY_WIDTH        = RSIP_INDEX_WIDTH + DST_IP_WIDTH;

  localparam int unsigned DST_IP_LSB     = 0;
  localparam int unsigned RSIP_INDEX_LSB = DST_IP_WIDTH;

  // Key as produced by the reliable-TX key selector.
  typedef struct packed {
    logic [RSIP_INDEX_WIDTH-1:0] rsip_index;
    logic [DST_IP_WIDTH-1:0]     dst_ip;
  } reli_tx_key_t;

endpackage

// File: rtl/lookup_prio_enc_reli_tx.sv
// Match vector to {any, lowest set index}; purely combinational.
module lookup_prio_enc_reli_tx
  import lookup_table_reli_tx_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IDX_WIDTH = 4
) (
  input  logic [DEPTH-1:0]     match,
  output logic                 any,
  output logic [IDX_WIDTH-1:0] index
);

  // Scan from the top so the lowest matching entry is the last to assign.
  always_comb begin
    index = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (match[i]) index = IDX_WIDTH'(i);
    end
  end

  assign any = |match;

endmodule

// File: rtl/lookup_table_reli_tx.sv
// Exact-match lookup engine for reliable-TX keys: two-stage pipeline with
// valid/ready result channel, config write port and hit/miss statistics.
module lookup_table_reli_tx
  import lookup_table_reli_tx_pkg::*;
#(
  parameter int unsigned KEY_WIDTH  = lookup_table_reli_tx_pkg::KEY_WIDTH,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IDX_WIDTH  = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_WIDTH-1:0]  s_key_info,
  input  logic                  s_key_valid,
  output logic                  s_key_ready,
  output logic                  m_result_hit,
  output logic                  m_result_bypass,
  output logic [IDX_WIDTH-1:0]  m_result_index,
  output logic [DATA_WIDTH-1:0] m_result_data,
  output logic                  m_result_valid,
  input  logic                  m_result_ready,
  input  logic                  cfg_wr_en,
  input  logic [IDX_WIDTH-1:0]  cfg_addr,
  input  logic                  cfg_entry_valid,
  input  logic [KEY_WIDTH-1:0]  cfg_key,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  output logic [CNT_WIDTH-1:0]  stat_lookup_cnt,
  output logic [CNT_WIDTH-1:0]  stat_hit_cnt,
  output logic [CNT_WIDTH-1:0]  stat_miss_cnt
);

  logic [DEPTH-1:0]      entry_valid;
  logic [KEY_WIDTH-1:0]  entry_key  [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data [DEPTH];

  logic                  s1_valid;
  logic [KEY_WIDTH-1:0]  s1_key;
  logic                  s1_key_zero_c;
  logic                  key_accept_c;
  logic                  s2_load_c;
  logic                  result_fire_c;

  logic [DEPTH-1:0]      match_c;
  logic                  match_any_c;
  logic [IDX_WIDTH-1:0]  match_index_c;

  // Table valid bits are reset; key/data storage is not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_valid <= '0;
    end else if (cfg_wr_en) begin
      entry_valid[cfg_addr] <= cfg_entry_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_wr_en) begin
      entry_key[cfg_addr]  <= cfg_key;
      entry_data[cfg_addr] <= cfg_data;
    end
  end

  // Handshake: S1 may refill whenever it is empty or is moving into S2 this cycle.
  assign s_key_ready   = !s1_valid || !m_result_valid || m_result_ready;
  assign key_accept_c  = s_key_valid && s_key_ready;
  assign s2_load_c     = s1_valid && (!m_result_valid || m_result_ready);
  assign result_fire_c = m_result_valid && m_result_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_key   <= '0;
    end else begin
      if (key_accept_c) begin
        s1_valid <= 1'b1;
        s1_key   <= s_key_info;
      end else if (s2_load_c) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // An all-zero key requests no lookup and must never match a stored zero key.
  assign s1_key_zero_c = (s1_key[RSIP_INDEX_LSB +: RSIP_INDEX_WIDTH] == '0) &&
                         (s1_key[DST_IP_LSB +: DST_IP_WIDTH] == '0);

  always_comb begin
    match_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      match_c[i] = entry_valid[i] && (entry_key[i] == s1_key) && !s1_key_zero_c;
    end
  end

  lookup_prio_enc_reli_tx #(
    .DEPTH     (DEPTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_prio_enc (
    .match (match_c),
    .any   (match_any_c),
    .index (match_index_c)
  );

  // Output stage: loads on advance, clears valid on drain, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_result_valid  <= 1'b0;
      m_result_hit    <= 1'b0;
      m_result_bypass <= 1'b0;
      m_result_index  <= '0;
      m_result_data   <= '0;
    end else if (s2_load_c) begin
      m_result_valid  <= 1'b1;
      m_result_hit    <= match_any_c;
      m_result_bypass <= s1_key_zero_c;
      m_result_index  <= match_any_c ? match_index_c : '0;
      m_result_data   <= match_any_c ? entry_data[match_index_c] : '0;
    end else if (result_fire_c) begin
      m_result_valid  <= 1'b0;
    end
  end

  // Saturating statistics, counted only for delivered non-bypass results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookup_cnt <= '0;
      stat_hit_cnt    <= '0;
      stat_miss_cnt   <= '0;
    end else if (result_fire_c && !m_result_bypass) begin
      if (stat_lookup_cnt != '1) stat_lookup_cnt <= stat_lookup_cnt + CNT_WIDTH'(1);
      if (m_result_hit) begin
        if (stat_hit_cnt != '1) stat_hit_cnt <= stat_hit_cnt + CNT_WIDTH'(1);
      end else begin
        if (stat_miss_cnt != '1) stat_miss_cnt <= stat_miss_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_lookup_table_reli_tx.sv
// Self-checking bench for lookup_table_reli_tx: directed scenarios plus a
// randomized stream checked against a table-scan reference model.
module tb_lookup_table_reli_tx;
  import lookup_table_reli_tx_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [132:0]  s_key_info = '0;
  logic          s_key_valid = 1'b0;
  logic          s_key_ready;
  logic          m_result_hit;
  logic          m_result_bypass;
  logic [3:0]    m_result_index;
  logic [31:0]   m_result_data;
  logic          m_result_valid;
  logic          m_result_ready = 1'b1;
  logic          cfg_wr_en = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic          cfg_entry_valid = 1'b0;
  logic [132:0]  cfg_key = '0;
  logic [31:0]   cfg_data = '0;
  logic [31:0]   stat_lookup_cnt;
  logic [31:0]   stat_hit_cnt;
  logic [31:0]   stat_miss_cnt;

  lookup_table_reli_tx dut (
    .clk             (clk),
    .rst             (rst),
    .s_key_info      (s_key_info),
    .s_key_valid     (s_key_valid),
    .s_key_ready     (s_key_ready),
    .m_result_hit    (m_result_hit),
    .m_result_bypass (m_result_bypass),
    .m_result_index  (m_result_index),
    .m_result_data   (m_result_data),
    .m_result_valid  (m_result_valid),
    .m_result_ready  (m_result_ready),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_addr        (cfg_addr),
    .cfg_entry_valid (cfg_entry_valid),
    .cfg_key         (cfg_key),
    .cfg_data        (cfg_data),
    .stat_lookup_cnt (stat_lookup_cnt),
    .stat_hit_cnt    (stat_hit_cnt),
    .stat_miss_cnt   (stat_miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic          mdl_valid [16];
  logic [132:0]  mdl_key   [16];
  logic [31:0]   mdl_data  [16];
  int            mdl_lookups = 0;
  int            mdl_hits    = 0;
  int            mdl_misses  = 0;
  logic [132:0]  key_q [$];
  logic [37:0]   exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected result {bypass, hit, index, data}: scan the table, first match wins.
  function automatic logic [37:0] model_lookup(input logic [132:0] k);
    logic hit = 1'b0;
    logic [3:0] idx = '0;
    logic [31:0] d = '0;
    if (k == '0) return {1'b1, 1'b0, 4'd0, 32'd0};
    for (int i = 0; i < 16; i++) begin
      if (!hit && mdl_valid[i] && mdl_key[i] == k) begin
        hit = 1'b1;
        idx = 4'(i);
        d   = mdl_data[i];
      end
    end
    return {1'b0, hit, idx, d};
  endfunction

  function automatic logic [37:0] cur_obs();
    return {m_result_bypass, m_result_hit, m_result_index, m_result_data};
  endfunction

  function automatic logic [132:0] rand_key();
    logic [159:0] r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return 133'(r) | 133'd1;
  endfunction

  task automatic count_stats(input logic [37:0] e);
    if (!e[37]) begin
      mdl_lookups++;
      if (e[36]) mdl_hits++;
      else mdl_misses++;
    end
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_lookup_cnt"}, 64'(stat_lookup_cnt), 64'(mdl_lookups));
    chk({tag, "_hit_cnt"},    64'(stat_hit_cnt),    64'(mdl_hits));
    chk({tag, "_miss_cnt"},   64'(stat_miss_cnt),   64'(mdl_misses));
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic v, input logic [132:0] k,
                           input logic [31:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_entry_valid = v; cfg_key = k; cfg_data = d;
    tick();
    cfg_wr_en = 1'b0;
    mdl_valid[a] = v; mdl_key[a] = k; mdl_data[a] = d;
  endtask

  // Single lookup on an idle pipeline with m_result_ready held high.
  task automatic send_one(input string tag, input logic [132:0] k);
    logic [37:0] e;
    e = model_lookup(k);
    s_key_valid = 1'b1; s_key_info = k;
    tick();
    s_key_valid = 1'b0; s_key_info = '0;
    chk({tag, "_not_yet"}, 64'(m_result_valid), 64'(0));
    tick();
    chk({tag, "_valid"}, 64'(m_result_valid), 64'(1));
    chk({tag, "_result"}, 64'(cur_obs()), 64'(e));
    tick();
    count_stats(e);
    chk({tag, "_drained"}, 64'(m_result_valid), 64'(0));
    check_stats(tag);
  endtask

  // Stream key_q through the DUT; pat 0: ready toggles 1010 and valid held, pat 1: random.
  task automatic stream(input string tag, input int pat);
    int n = key_q.size();
    int sent = 0, got = 0, cyc = 0, items = 0;
    logic stalled = 1'b0;
    logic [37:0] held = '0, e;
    while (got < n && cyc < 2000) begin
      m_result_ready = (pat == 0) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      s_key_valid    = (sent < n) && (pat == 0 || $urandom_range(0, 3) != 0);
      s_key_info     = s_key_valid ? key_q[sent] : '0;
      #1;
      if (stalled) chk({tag, "_stall_hold"}, 64'({m_result_valid, cur_obs()}), 64'({1'b1, held}));
      chk({tag, "_key_ready"}, 64'(s_key_ready), 64'(!(items == 2 && !m_result_ready)));
      if (m_result_valid && m_result_ready) begin
        e = exp_q.pop_front();
        chk({tag, "_result"}, 64'(cur_obs()), 64'(e));
        count_stats(e);
        got++; items--;
      end
      stalled = m_result_valid && !m_result_ready;
      held = cur_obs();
      if (s_key_valid && s_key_ready) begin
        exp_q.push_back(model_lookup(key_q[sent]));
        sent++; items++;
      end
      tick();
      cyc++;
    end
    s_key_valid = 1'b0; s_key_info = '0; m_result_ready = 1'b1;
    chk({tag, "_all_delivered"}, 64'(got), 64'(n));
    chk({tag, "_no_extra"}, 64'(m_result_valid), 64'(0));
    check_stats(tag);
  endtask

  initial begin
    logic [132:0] k1, k1_miss, k2, kz;
    k1      = {5'h02, 128'h2001_0db8_0000_0000_0000_0000_0000_0001};
    k1_miss = {5'h03, 128'h2001_0db8_0000_0000_0000_0000_0000_0001};
    k2      = {5'h07, 128'hfe80_0000_0000_0000_0000_0000_0000_0042};
    kz      = '0;
    for (int i = 0; i < 16; i++) begin
      mdl_valid[i] = 1'b0; mdl_key[i] = '0; mdl_data[i] = '0;
    end

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", 64'(m_result_valid), 64'(0));
    chk("rst_outputs", 64'(cur_obs()), 64'(0));
    chk("rst_key_ready", 64'(s_key_ready), 64'(1));
    check_stats("rst");

    // Bypass even when an entry stores key 0
    cfg_write(4'd0, 1'b1, kz, 32'h0000_0055);
    chk("bypass_model", 64'(model_lookup(kz)), 64'({1'b1, 37'd0}));
    send_one("bypass", kz);

    // Hit and miss
    cfg_write(4'd3, 1'b1, k1, 32'hCAFE_0003);
    send_one("hit", k1);
    chk("hit_index", 64'(m_result_index), 64'(3));
    send_one("miss", k1_miss);

    // Priority: lowest index wins, delete exposes next
    cfg_write(4'd9, 1'b1, k2, 32'd9);
    cfg_write(4'd4, 1'b1, k2, 32'd4);
    send_one("prio_low", k2);
    chk("prio_low_idx", 64'(m_result_index), 64'(4));
    cfg_write(4'd4, 1'b0, k2, 32'd4);
    send_one("prio_next", k2);
    chk("prio_next_idx", 64'(m_result_index), 64'(9));

    // Backpressure: 8 back-to-back hits, ready toggling
    key_q.delete();
    for (int i = 8; i < 16; i++) begin
      logic [132:0] rk;
      rk = rand_key();
      cfg_write(4'(i), 1'b1, rk, $urandom);
      key_q.push_back(rk);
    end
    stream("bp", 0);

    // Randomized mix of table keys, unknown keys and zero keys
    begin
      logic [132:0] tk [$];
      tk = key_q;
      key_q.delete();
      for (int i = 0; i < 60; i++) begin
        case ($urandom_range(0, 3))
          0:       key_q.push_back(rand_key());
          1:       key_q.push_back(kz);
          default: key_q.push_back(tk[$urandom_range(0, 7)]);
        endcase
      end
      key_q.push_back(k1);
      key_q.push_back(k2);
      stream("rnd", 1);
      key_q = tk;
    end

    // Write/lookup race: delete on the S1->S2 edge is not seen by that lookup
    s_key_valid = 1'b1; s_key_info = k1;
    tick();
    s_key_valid = 1'b0; s_key_info = '0;
    cfg_write(4'd3, 1'b0, k1, 32'hCAFE_0003);
    chk("race_valid", 64'(m_result_valid), 64'(1));
    chk("race_still_hit", 64'(cur_obs()), 64'({1'b0, 1'b1, 4'd3, 32'hCAFE_0003}));
    tick();
    count_stats({1'b0, 1'b1, 4'd3, 32'hCAFE_0003});
    check_stats("race");
    send_one("race_after", k1);
    chk("race_after_miss", 64'(m_result_hit), 64'(0));

    // Async reset with two results in flight
    m_result_ready = 1'b0;
    s_key_valid = 1'b1; s_key_info = key_q[0];
    tick();
    s_key_info = key_q[1];
    chk("inflight_ready", 64'(s_key_ready), 64'(1));
    tick();
    s_key_valid = 1'b0; s_key_info = '0;
    chk("inflight_full", 64'(s_key_ready), 64'(0));
    chk("inflight_valid", 64'(m_result_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_valid_drop", 64'(m_result_valid), 64'(0));
    chk("arst_outputs", 64'(cur_obs()), 64'(0));
    for (int i = 0; i < 16; i++) mdl_valid[i] = 1'b0;
    mdl_lookups = 0; mdl_hits = 0; mdl_misses = 0;
    check_stats("arst");
    tick();
    rst = 1'b0;
    m_result_ready = 1'b1;
    tick();
    chk("arst_no_ghost", 64'(m_result_valid), 64'(0));
    send_one("arst_former", key_q[0]);
    chk("arst_former_miss", 64'(m_result_hit), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not finish in time");
  end

endmodule

// File: doc/lookup_table_reli_tx.md
Name: lookup_table_reli_tx

Overview:
Exact-match lookup engine that consumes the 133-bit key produced by the reliable-TX key selector. The key is {rsip_index[4:0], dst_ip[127:0]}. The block returns hit/miss, the matching entry index and that entry's action data over a valid/ready result channel. The table is installed through a simple single-cycle config write port. Hit/miss statistics are kept for the control plane.

Parameters:
KEY_WIDTH, 133, lookup key width ({rsip_index, dst_ip}).
DATA_WIDTH, 32, action data stored per entry.
DEPTH, 16, number of table entries (power of two, >= 2).
IDX_WIDTH, 4, entry index width, must equal log2(DEPTH).
CNT_WIDTH, 32, statistics counter width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_key_info  in  KEY_WIDTH  lookup key
s_key_valid  in  1  key valid
s_key_ready  out  1  key ready
m_result_hit  out  1  key matched a valid entry
m_result_bypass  out  1  key was all-zero (no lookup requested)
m_result_index  out  IDX_WIDTH  matching entry index (0 on miss/bypass)
m_result_data  out  DATA_WIDTH  entry action data (0 on miss/bypass)
m_result_valid  out  1  result valid
m_result_ready  in  1  result ready
cfg_wr_en  in  1  table write strobe
cfg_addr  in  IDX_WIDTH  entry to write
cfg_entry_valid  in  1  valid bit to store (0 = delete)
cfg_key  in  KEY_WIDTH  key to store
cfg_data  in  DATA_WIDTH  data to store
stat_lookup_cnt  out  CNT_WIDTH  non-bypass lookups delivered
stat_hit_cnt  out  CNT_WIDTH  hits delivered
stat_miss_cnt  out  CNT_WIDTH  misses delivered

Behaviour:
- Reset (async, rst=1):
  - all entry valid bits cleared; stage registers empty;
  - m_result_valid=0, hit/bypass/index/data=0; all stat counters=0.
  - Entry key/data storage need not be reset.
  - Reset mid-flight discards any in-flight key silently.
- Pipeline, two stages:
  - S1 holds the accepted key.
  - S2 is the output register.
  - Key accepted at edge T (valid&&ready) -> result visible with m_result_valid=1 after edge T+1; latency 2 edges.
  - Full throughput of 1 key/cycle with m_result_ready held high.
- Handshake:
  - s_key_ready = !s1_valid || !m_result_valid || m_result_ready.
  - S1 advances into S2 when S2 is empty or being drained.
  - Outputs are held stable while m_result_valid && !m_result_ready.
  - s_key_ready has no combinational dependence on s_key_valid.
- Compare:
  - Done in the cycle S1 is occupied, against the current table contents.
  - A cfg write committed on the same edge that moves S1 into S2 is NOT seen by that lookup; a write committed earlier is seen.
- Match rule:
  - an entry matches iff valid && key == s1_key;
  - for multiple matches, the lowest index wins;
  - an all-zero key forces bypass=1, hit=0, index=0, data=0, and never matches, even if an entry holds key 0.
- Config:
  - cfg_wr_en writes all three fields of entry cfg_addr at the edge and is always accepted.
  - It has no interaction with the handshake.
- Statistics, updated on the result handshake (m_result_valid && m_result_ready):
  - non-bypass result: lookup_cnt+1, plus hit_cnt+1 or miss_cnt+1;
  - bypass result: no counter changes;
  - counters saturate at all-ones.

Decomposition:
- Shared reli_tx package holds:
  - KEY_WIDTH=133, RSIP_INDEX_WIDTH=5, DST_IP_WIDTH=128;
  - key field offsets (dst_ip at 0, rsip_index at 128).
- One sub-module is natural: lookup_prio_enc_reli_tx, a DEPTH-bit match vector -> {any, lowest index}, purely combinational.

Test Plan:
- Bypass: reset, send key 0 with an entry also holding key 0 -> bypass=1, hit=0, index=0, data=0, 2 edges after accept; counters unchanged.
- Hit and miss:
  - write entry 3 = {rsip 5'h02, dst_ip 128'h2001_0db8::1}, data 32'hCAFE0003;
  - send that key -> hit=1, index=3, data=CAFE0003, lookup_cnt=1, hit_cnt=1;
  - send rsip 5'h03 with the same ip -> hit=0, miss_cnt=1.
- Priority: write the same key to entries 9 (data 9) and 4 (data 4) -> index=4, data=4; delete entry 4 -> index=9, data=9.
- Backpressure:
  - 8 back-to-back hits with m_result_ready toggling 1010...;
  - all 8 results delivered in order; no drop or duplicate; outputs stable while stalled; s_key_ready low only when S1 and S2 are full and stalled.
- Write/lookup race: cfg delete of entry 3 on the same edge the key moves S1->S2 -> still a hit; the next lookup of that key -> miss.
- Async reset: assert rst with 2 results in flight -> m_result_valid drops immediately; the table is empty afterwards (former key misses); counters read 0.
